// File: rtl/send_data.sv
// Pattern-generating word source: streams `length` words of a selected pattern
// over a valid/ready handshake, with optional single-word bit-0 corruption.
module send_data (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] length,
    input  logic [1:0]  mode,
    input  logic [31:0] seed,
    input  logic        inject_error,
    input  logic        data_ready,
    output logic [31:0] dataout,
    output logic        data_valid,
    output logic        busy,
    output logic        done,
    output logic [31:0] word_count
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    localparam logic [1:0] ModeCounter = 2'd0;
    localparam logic [1:0] ModeWalk    = 2'd1;
    localparam logic [1:0] ModeLfsr    = 2'd2;
    localparam logic [1:0] ModeConst   = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] length_q, length_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] gen_q, gen_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;
    logic [31:0] dataout_q, dataout_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer;

    function automatic logic [31:0] first_word(input logic [1:0] m, input logic [31:0] s);
        logic [31:0] w;
        unique case (m)
            ModeCounter: w = s;
            ModeWalk:    w = 32'd1 << s[4:0];
            ModeLfsr:    w = (s == 32'd0) ? 32'd1 : s;
            ModeConst:   w = s;
            default:     w = s;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] next_word(input logic [1:0] m, input logic [31:0] w);
        logic [31:0] n;
        unique case (m)
            ModeCounter: n = w + 32'd1;
            ModeWalk:    n = {w[30:0], w[31]};
            ModeLfsr:    n = {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
            ModeConst:   n = w;
            default:     n = w;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        mode_d   = mode_q;
        gen_d    = gen_q;
        err_d    = err_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        xfer     = valid_q & data_ready;

        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (start) begin
                    length_d = length;
                    mode_d   = mode;
                    gen_d    = first_word(mode, seed);
                    count_d  = 32'd0;
                    if (length != 32'd0) begin
                        state_d = StSend;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StSend: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (xfer) begin
                    count_d = count_q + 32'd1;
                    gen_d   = next_word(mode_q, gen_q);
                    // A transfer consumes the armed flag; a request on the same edge re-arms it.
                    err_d   = inject_error;
                    if (count_d == length_q) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end else begin
                    err_d = err_q | inject_error;
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
        endcase

        // Registered copy of the offered word, so arming during a stall shows up immediately.
        dataout_d = gen_d ^ {31'd0, err_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            length_q  <= 32'd0;
            mode_q    <= 2'd0;
            gen_q     <= 32'd0;
            err_q     <= 1'b0;
            count_q   <= 32'd0;
            dataout_q <= 32'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            length_q  <= length_d;
            mode_q    <= mode_d;
            gen_q     <= gen_d;
            err_q     <= err_d;
            count_q   <= count_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dataout    = dataout_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = count_q;

endmodule
